// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction fetch stage: FSM state encoding
//   and the instruction value presented before anything has been fetched.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   DEPTH-entry FIFO of {pc, instr} fetched words. Push and pop in the same
//   cycle are legal at any occupancy, including full. Flush empties the FIFO
//   and discards that cycle's push and pop.
//   Ports: clk, reset (async, active-high)
//          push, push_pc, push_instr : write side
//          pop                       : remove head
//          flush                     : drop all entries
//          full, empty               : occupancy flags
//          head_pc, head_instr       : head entry, or last head when empty
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [31:0]       push_instr,
    input  logic              pop,
    input  logic              flush,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_pc,
    output logic [31:0]       head_instr
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] hold_pc;
    logic [31:0]       hold_instr;
    logic              pop_ok, push_ok;

    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign empty  = (count == '0);
    assign pop_ok  = pop && !empty && !flush;
    // A pop frees the slot this cycle, so a full buffer can still accept.
    assign push_ok = push && !flush && (!full || pop_ok);

    // Empty buffer shows the last head seen rather than stale storage.
    assign head_pc    = empty ? hold_pc    : pc_mem[rd_ptr];
    assign head_instr = empty ? hold_instr : instr_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            hold_pc    <= '0;
            hold_instr <= NOP_INSTR;
        end else begin
            if (!empty) begin
                hold_pc    <= pc_mem[rd_ptr];
                hold_instr <= instr_mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push_ok, pop_ok})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   PC register and fetch FSM in front of the instruction ROM. Fetched words
//   are queued with their PC in a prefetch buffer and handed downstream with
//   valid/ready. Redirects flush the buffer and reload the PC; fetching stops
//   once the PC leaves the loaded program.
//   Ports: clk, reset (async, active-high)
//          imem_addr/imem_data       : ROM word address and same-cycle data
//          out_valid/out_ready       : downstream handshake
//          out_instr/out_pc          : head instruction and its PC
//          redirect_valid/redirect_pc: branch/jump target
//          halted                    : FSM is in HALTED
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int PROG_LEN  = 32,
    parameter int RESET_PC  = 0,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] PC_END  = ADDR_W'(PROG_LEN);
    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              in_prog, buf_full, buf_empty, pop, fetch_en;

    assign imem_addr = pc;
    assign in_prog   = (pc < PC_END);
    assign out_valid = !buf_empty;
    // Redirect discards both this cycle's pop and fetch.
    assign pop       = out_valid && out_ready && !redirect_valid;
    assign fetch_en  = (state == FETCH) && in_prog && !redirect_valid &&
                       (!buf_full || pop);

    fetch_buffer #(
        .ADDR_W (ADDR_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (fetch_en),
        .push_pc    (pc),
        .push_instr (imem_data),
        .pop        (pop),
        .flush      (redirect_valid),
        .full       (buf_full),
        .empty      (buf_empty),
        .head_pc    (out_pc),
        .head_instr (out_instr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= BOOT;
            pc     <= PC_INIT;
            halted <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state  <= FETCH;
                    halted <= 1'b0;
                    if (redirect_valid) pc <= redirect_pc;
                end
                FETCH: begin
                    // An out-of-range redirect target halts on the next cycle.
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (!in_prog) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (fetch_en) begin
                        pc <= pc + ADDR_W'(1);
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (redirect_pc < PC_END) begin
                            state  <= FETCH;
                            halted <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= BOOT;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. The stimulus loads the ordered
// stream of PCs it expects downstream into a queue; an independent monitor
// compares every accepted handshake against the queue head.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        out_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr, imem_data, out_instr, out_pc;
    logic        out_valid, halted;

    int          cmp_n = 0;
    int          err_n = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    // ROM model: word i holds 0x100 + i.
    assign imem_data = 32'h100 + imem_addr;

    instruction_fetch_unit #(
        .ADDR_W    (32),
        .PROG_LEN  (32),
        .RESET_PC  (0),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_run(input int first, input int last);
        exp_q.delete();
        for (int i = first; i <= last; i++) exp_q.push_back(i);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: every accepted head must be the next expected PC.
    always @(negedge clk) begin : mon
        int unsigned e;
        if (!reset && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                cmp_n++;
                err_n++;
                $display("FAIL sb_unexpected: got pc %0h expected no output", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", out_pc, e);
                chk("sb_instr", out_instr, 32'h100 + e);
            end
        end
    end

    initial begin
        int k;
        // Reset state
        cyc(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, 0);

        // 1: streaming with out_ready high
        out_ready = 1'b1;
        expect_run(0, 31);
        reset = 1'b0;
        cyc(1);
        smp();
        chk("boot_no_valid", out_valid, 0);
        chk("boot_addr", imem_addr, 0);
        cyc(1);
        smp();
        chk("first_valid", out_valid, 1);
        chk("first_pc", out_pc, 0);
        cyc(6);

        // Async reset mid-stream
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_addr", imem_addr, 0);
        exp_q.delete();

        // 2: backpressure fills the buffer and freezes the PC
        out_ready = 1'b0;
        cyc(1);
        reset = 1'b0;
        expect_run(0, 31);
        cyc(7);
        smp();
        chk("bp_addr", imem_addr, 2);
        chk("bp_valid", out_valid, 1);
        chk("bp_head", out_pc, 0);
        cyc(1);
        smp();
        chk("bp_addr_stable", imem_addr, 2);
        cyc(1);
        out_ready = 1'b1;
        cyc(4);
        out_ready = 1'b0;
        cyc(4);
        smp();
        chk("full_valid", out_valid, 1);

        // 3: redirect while full
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'd20;
        exp_q.delete();
        expect_run(20, 31);
        out_ready = 1'b1;
        cyc(1);
        redirect_valid = 1'b0;
        smp();
        chk("flush_valid", out_valid, 0);
        cyc(1);
        smp();
        chk("redir_valid", out_valid, 1);
        chk("redir_pc", out_pc, 20);

        // 4: run off the end of the program
        k = 0;
        while (!halted && k < 40) begin
            cyc(1);
            k++;
        end
        chk("halt_reached", halted, 1);
        cyc(3);
        smp();
        chk("drained_valid", out_valid, 0);
        chk("all_popped", exp_q.size(), 0);
        chk("halt_addr", imem_addr, 32);
        chk("last_pc_held", out_pc, 31);

        // 5: out-of-range redirect keeps the unit halted
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'd40;
        cyc(1);
        redirect_valid = 1'b0;
        smp();
        chk("halt40_halted", halted, 1);
        chk("halt40_addr", imem_addr, 40);
        chk("halt40_valid", out_valid, 0);
        cyc(2);
        smp();
        chk("halt40_no_fetch", out_valid, 0);

        // 4 (cont.): in-range redirect restarts fetching
        cyc(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'd4;
        expect_run(4, 31);
        cyc(1);
        redirect_valid = 1'b0;
        smp();
        chk("restart_halted", halted, 0);
        cyc(1);
        smp();
        chk("restart_valid", out_valid, 1);
        chk("restart_pc", out_pc, 4);
        cyc(5);

        // 6: async reset mid-stream, checked before the next clock edge
        #2 reset = 1'b1;
        #1;
        chk("async2_valid", out_valid, 0);
        chk("async2_addr", imem_addr, 0);
        chk("async2_halted", halted, 0);
        exp_q.delete();
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
